control_bypass_hazard: RTL and testbench

- Parametrised successor to the EX-stage bypass control for the cached-memory RV32I pipeline.
- Produces per-source forwarding selects for NUM_SRC operands.
- Detects load-use and pending-load hazards, and raises pipeline stall/bubble.
- Captures MEM/WB results into per-source hold registers while the pipe is frozen on a cache miss, so retiring writebacks are not lost to a stalled EX instruction.

---
 rtl/control_bypass_hazard_if.sv | 38 +++
 rtl/control_bypass_hazard.sv | 114 +++++++++++
 tb/tb_control_bypass_hazard.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/control_bypass_hazard_if.sv
// rtl/control_bypass_hazard_if.sv - EX-stage bypass/hazard control signal bundle
interface control_bypass_hazard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] idex_rs;
  logic [NUM_SRC*REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0]         idex_rd;
  logic                      idex_memread;
  logic [REG_AW-1:0]         exmem_rd;
  logic                      exmem_regwrite;
  logic                      exmem_memread;
  logic                      mem_busy;
  logic                      mem_done;
  logic [REG_AW-1:0]         memwb_rd;
  logic                      memwb_regwrite;
  logic [DATA_W-1:0]         memwb_data;
  logic [NUM_SRC*3-1:0]      bypass_sel;
  logic [NUM_SRC*DATA_W-1:0] hold_data;
  logic                      stall_ifid;
  logic                      bubble_idex;
  logic                      pipe_freeze;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output idex_rs, ifid_rs, idex_rd, idex_memread, exmem_rd, exmem_regwrite,
           exmem_memread, mem_busy, mem_done, memwb_rd, memwb_regwrite, memwb_data,
    input  bypass_sel, hold_data, stall_ifid, bubble_idex, pipe_freeze, stall_count
  );

  modport slave (
    input  idex_rs, ifid_rs, idex_rd, idex_memread, exmem_rd, exmem_regwrite,
           exmem_memread, mem_busy, mem_done, memwb_rd, memwb_regwrite, memwb_data,
    output bypass_sel, hold_data, stall_ifid, bubble_idex, pipe_freeze, stall_count
  );
endinterface

// File: rtl/control_bypass_hazard.sv
// rtl/control_bypass_hazard.sv - EX-stage forwarding selects, hazard stalls and miss-time writeback holding
module control_bypass_hazard #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  control_bypass_hazard_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [NUM_SRC-1:0]        hold_valid_q, hold_valid_d;
  logic [NUM_SRC*DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]          stall_count_q, stall_count_d;

  logic [REG_AW-1:0]    ex_rs [NUM_SRC];
  logic [REG_AW-1:0]    id_rs [NUM_SRC];
  logic [NUM_SRC*3-1:0] sel;
  logic                 freeze, load_use, pending_load, stall, bubble, hold_ok, capture_en;

  // unpack the flat source-address buses into per-source arrays
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_rs[i] = bus.idex_rs[i*REG_AW +: REG_AW];
      id_rs[i] = bus.ifid_rs[i*REG_AW +: REG_AW];
    end
  end

  // forwarding select priority and hazard detection; reset silences every output
  always_comb begin
    freeze       = bus.mem_busy & ~bus.mem_done;
    hold_ok      = (state_q == MISS) || (state_q == DRAIN);
    load_use     = 1'b0;
    pending_load = 1'b0;
    sel          = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_rs[i] != '0) begin
        if (bus.mem_done && bus.exmem_memread && bus.exmem_rd == ex_rs[i])
          sel[i*3 +: 3] = 3'b011;
        else if (bus.exmem_regwrite && !bus.exmem_memread && bus.exmem_rd == ex_rs[i])
          sel[i*3 +: 3] = 3'b010;
        else if (bus.memwb_regwrite && bus.memwb_rd == ex_rs[i])
          sel[i*3 +: 3] = 3'b001;
        else if (hold_valid_q[i] && hold_ok)
          sel[i*3 +: 3] = 3'b100;
        // a load still in flight for this operand: EX must wait for its data
        if (bus.exmem_memread && bus.exmem_regwrite && bus.exmem_rd == ex_rs[i] && !bus.mem_done)
          pending_load = 1'b1;
      end
      if (bus.idex_memread && bus.idex_rd != '0 && bus.idex_rd == id_rs[i])
        load_use = 1'b1;
    end
    // a frozen pipe keeps ID/EX intact, so no bubble is injected
    stall  = freeze | load_use | pending_load;
    bubble = ~freeze & (load_use | pending_load);
    if (reset) begin
      sel    = '0;
      stall  = 1'b0;
      bubble = 1'b0;
      freeze = 1'b0;
    end
  end

  // miss FSM next state, hold capture/clear and saturating stall counter
  always_comb begin
    state_d       = state_q;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    stall_count_d = stall_count_q;
    capture_en    = (state_q == MISS) || (state_q == IDLE && freeze);
    case (state_q)
      IDLE:    if (freeze) state_d = MISS;
      MISS:    if (!freeze) state_d = DRAIN;
      DRAIN:   state_d = freeze ? MISS : IDLE;
      default: state_d = IDLE;
    endcase
    // EX consumes its held operands as the pipe resumes after DRAIN
    if (state_q == DRAIN && !freeze)
      hold_valid_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (capture_en && bus.memwb_regwrite && bus.memwb_rd != '0 && bus.memwb_rd == ex_rs[i]) begin
        hold_data_d[i*DATA_W +: DATA_W] = bus.memwb_data;
        hold_valid_d[i]                 = 1'b1;
      end
    end
    if (stall && stall_count_q != '1)
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  // state registers with synchronous reset that overrides any capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_valid_q  <= '0;
      hold_data_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.bypass_sel  = sel;
  assign bus.hold_data   = hold_data_q;
  assign bus.stall_ifid  = stall;
  assign bus.bubble_idex = bubble;
  assign bus.pipe_freeze = freeze;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_control_bypass_hazard.sv
// tb/tb_control_bypass_hazard.sv - scoreboard bench for control_bypass_hazard
module tb_control_bypass_hazard;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  control_bypass_hazard_if #(.NUM_SRC(2), .REG_AW(5), .DATA_W(32), .CNT_W(4)) bus ();

  control_bypass_hazard #(.NUM_SRC(2), .REG_AW(5), .DATA_W(32), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [5:0]  sel;
    logic        stall;
    logic        bubble;
    logic        freeze;
    bit          chk_cnt;
    logic [3:0]  cnt;
    bit          chk_h0;
    logic [31:0] h0;
    bit          chk_h1;
    logic [31:0] h1;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] exp_cnt = 4'd0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, want);
    end
  endtask

  task automatic clr();
    reset              = 1'b0;
    bus.idex_rs        = '0;
    bus.ifid_rs        = '0;
    bus.idex_rd        = '0;
    bus.idex_memread   = 1'b0;
    bus.exmem_rd       = '0;
    bus.exmem_regwrite = 1'b0;
    bus.exmem_memread  = 1'b0;
    bus.mem_busy       = 1'b0;
    bus.mem_done       = 1'b0;
    bus.memwb_rd       = '0;
    bus.memwb_regwrite = 1'b0;
    bus.memwb_data     = '0;
  endtask

  task automatic set_ex(input int i, input logic [4:0] v);
    bus.idex_rs[i*5 +: 5] = v;
  endtask

  task automatic set_id(input int i, input logic [4:0] v);
    bus.ifid_rs[i*5 +: 5] = v;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.memwb_rd       = rd;
    bus.memwb_regwrite = 1'b1;
    bus.memwb_data     = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  // expected response for the vector just applied; counter model tracks stall history
  task automatic push(input string nm, input logic [2:0] s0, input logic [2:0] s1,
                      input logic st, input logic bu, input logic fr, input bit is_rst,
                      input bit c0, input logic [31:0] h0, input bit c1, input logic [31:0] h1);
    exp_t e;
    e.nm = nm; e.sel = {s1, s0}; e.stall = st; e.bubble = bu; e.freeze = fr;
    e.chk_cnt = !is_rst; e.cnt = exp_cnt;
    e.chk_h0 = c0; e.h0 = h0; e.chk_h1 = c1; e.h1 = h1;
    sb.push_back(e);
    if (is_rst) exp_cnt = 4'd0;
    else if (st && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  // monitor: compare DUT outputs on the falling edge against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "sel", 32'(bus.bypass_sel), 32'(e.sel));
        chk(e.nm, "stall", 32'(bus.stall_ifid), 32'(e.stall));
        chk(e.nm, "bubble", 32'(bus.bubble_idex), 32'(e.bubble));
        chk(e.nm, "freeze", 32'(bus.pipe_freeze), 32'(e.freeze));
        if (e.chk_cnt) chk(e.nm, "cnt", 32'(bus.stall_count), 32'(e.cnt));
        if (e.chk_h0)  chk(e.nm, "hold0", bus.hold_data[31:0], e.h0);
        if (e.chk_h1)  chk(e.nm, "hold1", bus.hold_data[63:32], e.h1);
      end
    end
  end

  initial begin
    clr();
    // reset with busy/forwarding inputs present: all outputs must be silent
    step(); reset = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_regwrite = 1'b1; set_ex(0, 5'd5);
    bus.mem_busy = 1'b1; bus.idex_memread = 1'b1; bus.idex_rd = 5'd7; set_id(1, 5'd7);
    push("rst_out", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(); push("rst_state", 3'b000, 3'b000, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0);
    // ALU chain: EX/MEM wins over MEM/WB, x0 never forwards
    step(); set_ex(0, 5'd5); bus.exmem_rd = 5'd5; bus.exmem_regwrite = 1'b1; wb(5'd5, 32'h1);
    push("alu_chain", 3'b010, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); bus.exmem_rd = 5'd0; bus.exmem_regwrite = 1'b1; wb(5'd0, 32'h2);
    push("x0", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); set_ex(0, 5'd4); set_ex(1, 5'd9); wb(5'd9, 32'h3);
    push("memwb", 3'b000, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use then load data forwarding
    step(); bus.idex_memread = 1'b1; bus.idex_rd = 5'd7; set_id(1, 5'd7);
    push("load_use", 3'b000, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0);
    step(); bus.exmem_memread = 1'b1; bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd7;
    bus.mem_done = 1'b1; set_ex(1, 5'd7);
    push("load_fwd", 3'b000, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); bus.exmem_memread = 1'b1; bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd7; set_ex(0, 5'd7);
    push("pend_load", 3'b000, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0);
    step(); bus.idex_memread = 1'b1; bus.idex_rd = 5'd0;
    push("lu_x0", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    // miss with writeback captured into hold register 0
    step(); bus.mem_busy = 1'b1; set_ex(0, 5'd3); bus.idex_memread = 1'b1; bus.idex_rd = 5'd7; set_id(0, 5'd7);
    push("miss1_lu", 3'b000, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.mem_busy = 1'b1; set_ex(0, 5'd3); wb(5'd3, 32'hDEADBEEF);
    push("miss2_wb", 3'b001, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.mem_busy = 1'b1; set_ex(0, 5'd3);
    push("miss3_hold", 3'b100, 3'b000, 1, 0, 1, 0, 1, 32'hDEADBEEF, 1, 32'h0);
    step(); bus.mem_busy = 1'b1; set_ex(0, 5'd3);
    push("miss4", 3'b100, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0);
    step(); set_ex(0, 5'd3);
    push("unfreeze", 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); set_ex(0, 5'd3);
    push("drain", 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); set_ex(0, 5'd3);
    push("hold_clr", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back misses: hold 1 kept across DRAIN->MISS then overwritten
    step(); bus.mem_busy = 1'b1; set_ex(0, 5'd3); set_ex(1, 5'd6); wb(5'd6, 32'h11111111);
    push("b2b_cap", 3'b000, 3'b001, 1, 0, 1, 0, 0, 0, 0, 0);
    step(); set_ex(1, 5'd6);
    push("b2b_drop", 3'b000, 3'b100, 0, 0, 0, 0, 0, 0, 1, 32'h11111111);
    step(); bus.mem_busy = 1'b1; set_ex(1, 5'd6);
    push("b2b_refrz", 3'b000, 3'b100, 1, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.mem_busy = 1'b1; set_ex(1, 5'd6);
    push("b2b_kept", 3'b000, 3'b100, 1, 0, 1, 0, 0, 0, 1, 32'h11111111);
    step(); bus.mem_busy = 1'b1; set_ex(1, 5'd6); wb(5'd6, 32'h22222222);
    push("b2b_wb2", 3'b000, 3'b001, 1, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.mem_busy = 1'b1; set_ex(1, 5'd6);
    push("b2b_ovw", 3'b000, 3'b100, 1, 0, 1, 0, 0, 0, 1, 32'h22222222);
    // reset in the middle of a miss
    step(); reset = 1'b1; bus.mem_busy = 1'b1; set_ex(1, 5'd6);
    push("rst_miss", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(); set_ex(1, 5'd6);
    push("post_rst", 3'b000, 3'b000, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0);
    // stall counter saturation
    for (int k = 0; k < 20; k++) begin
      step(); bus.mem_busy = 1'b1;
      push("sat_frz", 3'b000, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      push("sat_idle", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    step(); bus.exmem_memread = 1'b1; bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd7; set_ex(0, 5'd7);
    push("sat_pend", 3'b000, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0);
    // busy together with done is not a freeze and forwards load data
    step(); bus.mem_busy = 1'b1; bus.mem_done = 1'b1; bus.exmem_memread = 1'b1;
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd4; set_ex(0, 5'd4);
    push("busy_done", 3'b011, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    #1;
    chk("drain_sb", "pending", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
